// File: rtl/bus_if_pkg.sv
// Shared types for the processor-side burst bus master.
// Request fields are sized for the widest supported configuration.
package bus_if_pkg;

  localparam int ADDR_W_MAX = 64;
  localparam int LEN_W_MAX  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA
  } bus_state_e;

  typedef struct packed {
    logic                  read;
    logic [ADDR_W_MAX-1:0] addr;
    logic [LEN_W_MAX-1:0]  len;
  } req_t;

  // Bit offset of address beat k, most significant beat first.
  function automatic int beat_shift(int beats, int k, int w);
    return (beats - 1 - k) * w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// Loadable up-counter with a terminal-count compare.
// Shared by the address beat, data beat and timeout counters.
module bus_beat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority over increment.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/bus_master_burst_if.sv
// Processor-side master for the multiplexed start/read/address/data bus.
// One request at a time: address beats MSB-first, then 1..MAX_BURST data beats.
module bus_master_burst_if
  import bus_if_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_BEATS = 2,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 15,
  parameter int LEN_W      = $clog2(MAX_BURST),
  parameter int ADDR_W     = DATA_W * ADDR_BEATS
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              start,
  output logic              read,
  output logic [DATA_W-1:0] address,
  inout  logic [DATA_W-1:0] data,
  inout  logic              dataValid
);

  localparam int ACNT_W = cnt_w(ADDR_BEATS);
  localparam int TCNT_W = cnt_w(TIMEOUT + 1);

  bus_state_e state_q, state_d;
  req_t       req_q, req_d;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              addr_oe;
  logic              data_oe;
  logic [DATA_W-1:0] addr_beat;

  logic              a_load, a_inc, a_term;
  logic              d_load, d_inc, d_term;
  logic              t_load, t_inc, t_term;
  logic [ACNT_W-1:0] a_cnt;
  logic [LEN_W-1:0]  d_cnt;
  logic [TCNT_W-1:0] t_cnt;

  bus_beat_counter #(.W(ACNT_W)) u_addr_cnt (
    .clock    (clock),
    .resetN   (resetN),
    .load     (a_load),
    .load_val ('0),
    .inc      (a_inc),
    .term     (ACNT_W'(ADDR_BEATS - 1)),
    .count    (a_cnt),
    .at_term  (a_term)
  );

  bus_beat_counter #(.W(LEN_W)) u_data_cnt (
    .clock    (clock),
    .resetN   (resetN),
    .load     (d_load),
    .load_val ('0),
    .inc      (d_inc),
    .term     (LEN_W'(req_q.len)),
    .count    (d_cnt),
    .at_term  (d_term)
  );

  bus_beat_counter #(.W(TCNT_W)) u_tmo_cnt (
    .clock    (clock),
    .resetN   (resetN),
    .load     (t_load),
    .load_val ('0),
    .inc      (t_inc),
    .term     (TCNT_W'(TIMEOUT - 1)),
    .count    (t_cnt),
    .at_term  (t_term)
  );

  assign addr_beat = DATA_W'(req_q.addr >>
                     beat_shift(ADDR_BEATS, int'(a_cnt), DATA_W));

  // Next-state, strobes and registered-output updates; bus drops during reset.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    a_load     = 1'b0;
    a_inc      = 1'b0;
    d_load     = 1'b0;
    d_inc      = 1'b0;
    t_load     = 1'b0;
    t_inc      = 1'b0;
    req_ready  = 1'b0;
    start      = 1'b0;
    read       = 1'b0;
    wr_ready   = 1'b0;
    addr_oe    = 1'b0;
    data_oe    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.read = req_read;
          req_d.addr = ADDR_W_MAX'(req_addr);
          req_d.len  = LEN_W_MAX'(req_len);
          a_load     = 1'b1;
          d_load     = 1'b1;
          t_load     = 1'b1;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_oe = 1'b1;
        start   = (a_cnt == '0);
        if (a_term) begin
          read    = req_q.read;
          state_d = req_q.read ? ST_RDATA : ST_WDATA;
        end else begin
          a_inc = 1'b1;
        end
      end
      ST_RDATA: begin
        if (dataValid) begin
          rd_data_d  = data;
          rd_valid_d = 1'b1;
          d_inc      = 1'b1;
          t_load     = 1'b1;
          if (d_term) begin
            rd_last_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          t_inc = 1'b1;
          if (TIMEOUT != 0 && t_term) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WDATA: begin
        data_oe  = 1'b1;
        wr_ready = wr_valid;
        if (wr_valid) begin
          d_inc = 1'b1;
          if (d_term) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!resetN) begin
      req_ready = 1'b0;
      start     = 1'b0;
      read      = 1'b0;
      wr_ready  = 1'b0;
      addr_oe   = 1'b0;
      data_oe   = 1'b0;
    end
  end

  // State, latched request and registered core-side outputs.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;
  assign err      = err_q;

  assign address   = addr_oe ? addr_beat : {DATA_W{1'bz}};
  assign data      = data_oe ? wr_data : {DATA_W{1'bz}};
  assign dataValid = data_oe ? wr_valid : 1'bz;

endmodule

// File: tb/tb_bus_master_burst_if.sv
// Bench for bus_master_burst_if: randomized reads/writes against a cycle
// timeline model, plus timeout, reset and single-address-beat scenarios.
module tb_bus_master_burst_if;

  localparam int T = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        resetN;
  logic        req_valid, req_ready, req_read;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_last, done, err, start, read;
  logic [7:0]  rd_data;
  tri1  [7:0]  address8;
  tri1  [7:0]  data8;
  tri0         dv8;
  logic        s_en, s_dv;
  logic [7:0]  s_data;

  assign data8 = s_en ? s_data : 8'hzz;
  assign dv8   = s_en ? s_dv : 1'bz;

  bus_master_burst_if #(
    .DATA_W(8), .ADDR_BEATS(2), .MAX_BURST(4), .TIMEOUT(T)
  ) dut (
    .clock(clk), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .start(start), .read(read),
    .address(address8), .data(data8), .dataValid(dv8)
  );

  logic        q16_valid, q16_ready, q16_read;
  logic [15:0] q16_addr;
  logic [1:0]  q16_len;
  logic        w16_valid, w16_ready;
  logic [15:0] w16_data;
  logic        r16_valid, r16_last, done16, err16, start16, read16;
  logic [15:0] r16_data;
  tri1  [15:0] address16;
  tri1  [15:0] data16;
  tri0         dv16;
  logic        s16_en, s16_dv;
  logic [15:0] s16_data;

  assign data16 = s16_en ? s16_data : 16'hzzzz;
  assign dv16   = s16_en ? s16_dv : 1'bz;

  bus_master_burst_if #(
    .DATA_W(16), .ADDR_BEATS(1), .MAX_BURST(4), .TIMEOUT(T)
  ) dut16 (
    .clock(clk), .resetN(resetN),
    .req_valid(q16_valid), .req_ready(q16_ready),
    .req_read(q16_read), .req_addr(q16_addr), .req_len(q16_len),
    .wr_valid(w16_valid), .wr_ready(w16_ready), .wr_data(w16_data),
    .rd_valid(r16_valid), .rd_data(r16_data), .rd_last(r16_last),
    .done(done16), .err(err16), .start(start16), .read(read16),
    .address(address16), .data(data16), .dataValid(dv16)
  );

  int         gap_a[4];
  logic [7:0] dat_a[4];

  task automatic step();
    @(negedge clk);
  endtask

  // Request in the current cycle, then check both address beats.
  task automatic addr_phase(input logic [15:0] a, input int len,
                            input logic rd);
    req_valid = 1'b1; req_read = rd; req_addr = a; req_len = 2'(len);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    #1;
    checks++;
    if ({start, read, address8} !== {2'b10, a[15:8]}) begin
      errors++;
      $display("FAIL addr_beat0: got s=%b r=%b a=%h want s=1 r=0 a=%h",
               start, read, address8, a[15:8]);
    end
    step();
    #1;
    checks++;
    if ({start, read, address8} !== {1'b0, rd, a[7:0]}) begin
      errors++;
      $display("FAIL addr_beat1: got s=%b r=%b a=%h want s=0 r=%b a=%h",
               start, read, address8, rd, a[7:0]);
    end
  endtask

  // Read transfer; the slave answers beat b after gap_a[b] silent cycles.
  task automatic read_xfer(input logic [15:0] a, input int len);
    int idle, b;
    bit pv, pl, pe, fin, beat;
    logic [7:0] pd;
    addr_phase(a, len, 1'b1);
    idle = 0; b = 0; pv = 0; pl = 0; pe = 0; fin = 0; pd = '0;
    forever begin
      step();
      beat = 1'b0;
      if (!fin) begin
        beat = (idle == gap_a[b]);
        s_en = 1'b1; s_dv = beat;
        s_data = beat ? dat_a[b] : 8'($urandom);
      end else begin
        s_en = 1'b0; s_dv = 1'b0;
      end
      #1;
      checks++;
      if (rd_valid !== pv || (pv && rd_data !== pd)) begin
        errors++;
        $display("FAIL rd_beat: got v=%b d=%h want v=%b d=%h",
                 rd_valid, rd_data, pv, pd);
      end
      checks++;
      if ({rd_last, done, err} !== {pl, pl | pe, pe}) begin
        errors++;
        $display("FAIL rd_status: got last=%b done=%b err=%b want %b %b %b",
                 rd_last, done, err, pl, pl | pe, pe);
      end
      checks++;
      if (req_ready !== fin) begin
        errors++; $display("FAIL rd_req_ready: got %b want %b", req_ready, fin);
      end
      if (fin) break;
      if (beat) begin
        pv = 1; pd = dat_a[b]; pl = (b == len); pe = 0;
        fin = (b == len); b++; idle = 0;
      end else begin
        pv = 0; pl = 0; idle++; pe = (idle == T); fin = pe;
      end
    end
  endtask

  // Write transfer; wr_valid stays low gap_a[b] cycles before beat b.
  task automatic write_xfer(input logic [15:0] a, input int len);
    int wait_c, w;
    bit pd, fin, v;
    addr_phase(a, len, 1'b0);
    wait_c = 0; w = 0; pd = 0; fin = 0;
    forever begin
      step();
      v = 1'b0;
      if (!fin) begin
        v = (wait_c == gap_a[w]);
        wr_valid = v;
        wr_data = v ? dat_a[w] : 8'($urandom);
      end else begin
        wr_valid = 1'b0; wr_data = 8'h00;
      end
      #1;
      checks++;
      if (done !== pd || err !== 1'b0) begin
        errors++;
        $display("FAIL wr_done: got done=%b err=%b want done=%b err=0",
                 done, err, pd);
      end
      if (fin) begin
        checks++;
        if ({req_ready, dv8, data8} !== {2'b10, 8'hFF}) begin
          errors++;
          $display("FAIL wr_release: got rdy=%b dv=%b d=%h want 1 0 ff",
                   req_ready, dv8, data8);
        end
        break;
      end
      checks++;
      if ({wr_ready, dv8, data8, req_ready} !== {v, v, wr_data, 1'b0}) begin
        errors++;
        $display("FAIL wr_beat: got rdy=%b dv=%b d=%h rq=%b want %b %b %h 0",
                 wr_ready, dv8, data8, req_ready, v, v, wr_data);
      end
      if (v) begin
        pd = (w == len); fin = (w == len); w++; wait_c = 0;
      end else begin
        pd = 0; wait_c++;
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    step(); step();
    #1;
    checks++;
    if ({req_ready, start, read, wr_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_forced: got rdy=%b s=%b r=%b wr=%b want 0",
               req_ready, start, read, wr_ready);
    end
    step();
    resetN = 1'b1;
    #1;
    checks++;
    if ({rd_valid, rd_last, done, err, rd_data, req_ready, address8}
        !== {4'b0, 8'h00, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b d=%b e=%b rd=%h rq=%b a=%h",
               rd_valid, rd_last, done, err, rd_data, req_ready, address8);
    end
  endtask

  task automatic test_read_basic();
    gap_a[0] = 1; dat_a[0] = 8'h3C;
    read_xfer(16'hA5C3, 0);
  endtask

  task automatic test_burst_write();
    gap_a = '{0, 0, 2, 0};
    dat_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_xfer(16'h4321, 3);
  endtask

  task automatic test_timeout();
    gap_a[0] = 20; dat_a[0] = 8'hEE;
    read_xfer(16'h0102, 0);
    gap_a[0] = T - 1; dat_a[0] = 8'h5D;
    read_xfer(16'h0304, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      int len;
      bit rd;
      len = $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) begin
        gap_a[j] = $urandom_range(0, rd ? 4 : 3);
        dat_a[j] = 8'($urandom);
      end
      if (rd) read_xfer(16'($urandom), len);
      else write_xfer(16'($urandom), len);
    end
  endtask

  task automatic test_reset_mid();
    addr_phase(16'h5A3C, 3, 1'b1);
    step();
    s_en = 1'b1; s_dv = 1'b1; s_data = 8'h77;
    step();
    s_data = 8'h88; resetN = 1'b0;
    #1;
    checks++;
    if ({start, read, wr_ready, req_ready, address8} !== {4'b0, 8'hFF}) begin
      errors++;
      $display("FAIL reset_mid_bus: got s=%b r=%b wr=%b rq=%b a=%h",
               start, read, wr_ready, req_ready, address8);
    end
    step();
    resetN = 1'b1; s_en = 1'b0; s_dv = 1'b0;
    #1;
    checks++;
    if ({rd_valid, done, err, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_after: got v=%b d=%b e=%b rq=%b want 0 0 0 1",
               rd_valid, done, err, req_ready);
    end
    req_valid = 1'b1; req_read = 1'b0; req_addr = 16'h1234; req_len = 2'd0;
    step();
    req_valid = 1'b0; resetN = 1'b0;
    #1;
    checks++;
    if ({start, address8} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL reset_addr_release: got s=%b a=%h want 0 ff",
               start, address8);
    end
    step();
    resetN = 1'b1;
    #1;
    checks++;
    if ({req_ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL reset_addr_idle: got rq=%b d=%b want 1 0", req_ready, done);
    end
    for (int j = 0; j < 4; j++) begin
      gap_a[j] = j; dat_a[j] = 8'(8'hA0 + j);
    end
    read_xfer(16'h9876, 3);
  endtask

  task automatic test_single_addr_beat();
    q16_valid = 1'b1; q16_read = 1'b1; q16_addr = 16'hBEEF; q16_len = 2'd0;
    step();
    q16_valid = 1'b0;
    #1;
    checks++;
    if ({start16, read16, address16} !== {2'b11, 16'hBEEF}) begin
      errors++;
      $display("FAIL ab1_addr: got s=%b r=%b a=%h want 1 1 beef",
               start16, read16, address16);
    end
    step();
    s16_en = 1'b1; s16_dv = 1'b1; s16_data = 16'h1234;
    #1;
    checks++;
    if (r16_valid !== 1'b0) begin
      errors++; $display("FAIL ab1_early: got rd_valid=%b want 0", r16_valid);
    end
    step();
    s16_en = 1'b0; s16_dv = 1'b0;
    #1;
    checks++;
    if ({r16_valid, r16_last, done16, err16, r16_data}
        !== {4'b1110, 16'h1234}) begin
      errors++;
      $display("FAIL ab1_rd: got v=%b l=%b d=%b e=%b rd=%h want 1 1 1 0 1234",
               r16_valid, r16_last, done16, err16, r16_data);
    end
  endtask

  initial begin
    resetN = 1'b0;
    req_valid = 0; req_read = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0; s_en = 0; s_dv = 0; s_data = '0;
    q16_valid = 0; q16_read = 0; q16_addr = '0; q16_len = '0;
    w16_valid = 0; w16_data = '0; s16_en = 0; s16_dv = 0; s16_data = '0;
    test_reset();
    test_read_basic();
    test_burst_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_single_addr_beat();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bus_master_burst_if.md
# bus_master_burst_if

Processor-side bus interface for the shared multiplexed start/read/address/data/dataValid bus, generalised over data width, address beat count and burst length. Accepts one request at a time from the processor core, issues address beats MSB-first, then moves 1..MAX_BURST data beats in either direction. A read-timeout aborts the transfer with an error. It replaces the fixed 8-bit, 2-beat, single-transfer processor thread and sits between the core and the memory-side interface.

## Interface
- DATA_W, 8: bus data/address beat width
- ADDR_BEATS, 2: address beats per transfer (≥1); full address is DATA_W*ADDR_BEATS bits
- MAX_BURST, 4: max data beats per transfer, power of two ≥2; LEN_W = $clog2(MAX_BURST)
- TIMEOUT, 15: max consecutive idle cycles waiting for read dataValid; 0 disables
- clock  in  1  single clock, all state on posedge
- resetN  in  1  synchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_read  in  1  1 = read, 0 = write
- req_addr  in  DATA_W*ADDR_BEATS  transfer address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed this cycle
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat returned
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  with rd_valid: final beat
- done  out  1  one-cycle pulse: transfer finished or aborted
- err  out  1  with done: read timeout
- start  out  1  bus start strobe
- read  out  1  bus read strobe
- address  out  DATA_W  bus address beat, high-Z when not driving
- data  inout  DATA_W  bus data, driven only on write beats
- dataValid  inout  1  driven only in WDATA, else high-Z

## Operation
- States: IDLE, ADDR, RDATA, WDATA.
- IDLE: req_ready=1; on req_valid latch addr, read, len; clear counters; -> ADDR.
- ADDR: beat k drives address = addr slice [(ADDR_BEATS-1-k)*DATA_W +: DATA_W]. start=1 on beat 0 only. read=latched read on final beat only. After the final beat -> RDATA (read) or WDATA (write).
- RDATA: sample data when dataValid=1. Register it to rd_data with rd_valid=1 next cycle. Increment beat count and clear the timeout counter. The beat where count==len sets rd_last and done on that same registered cycle, and state -> IDLE. On a cycle without dataValid, increment the timeout counter. When it reaches TIMEOUT: done=1, err=1, -> IDLE, rd_valid not asserted.
- WDATA: drive dataValid=wr_valid and data=wr_data combinationally; wr_ready=wr_valid. Each accepted beat increments the count. On the beat with count==len, done pulses next cycle and state -> IDLE. No timeout on writes.
- ADDR_BEATS=1: start and read assert in the same cycle.
- Unused slave dataValid in WDATA or ADDR is ignored.

## Timing
- Request accepted at edge N; first address beat (start) in cycle N+1; data phase begins at cycle N+1+ADDR_BEATS.
- Read beat on bus in cycle M → rd_valid in cycle M+1.
- Back-to-back: req_ready returns the cycle after the final data beat. Minimum transfer is ADDR_BEATS+1 bus cycles plus 1 idle cycle.
- Reset is sampled on the edge. While resetN=0, start, read and wr_ready are forced to 0 and address/data/dataValid are released combinationally. After the edge: state IDLE, counters 0, rd_valid=0, rd_last=0, done=0, err=0, rd_data=0. req_ready=0 while resetN=0.
- Reset mid-transfer aborts without a done pulse. The bus is released in the same cycle that resetN is low.
- Timeout boundary: with TIMEOUT=T, err fires after exactly T consecutive idle cycles in RDATA. A dataValid on cycle T is treated as a beat, not a timeout.

## Structure
- Package bus_if_pkg: state enum bus_state_e, and a req_t struct {read, addr, len}, parametrised via localparams.
- Sub-module bus_beat_counter (load/increment/terminal-count flag). It is instantiated for the address beat, data beat and timeout counters.
- Tri-state assigns live in the top level only.

## Test plan
- Reset then read: DATA_W=8, ADDR_BEATS=2, req addr=0xA5C3, len=0. Expect start with address=0xA5, then address=0xC3 with read=1. Slave returns 0x3C → rd_valid/rd_last/done with rd_data=0x3C. err=0.
- Burst write: len=3, wr_data 0x11,0x22,0x33,0x44, with wr_valid low for 2 cycles mid-burst. Expect exactly 4 dataValid cycles carrying those values, then done one cycle after 0x44.
- Read timeout: TIMEOUT=15, slave silent. Expect done=1, err=1 on the 15th idle cycle, no rd_valid, and req_ready back high.
- Timeout edge: slave asserts dataValid exactly on idle cycle 15. Expect a normal beat and no err.
- ADDR_BEATS=1, DATA_W=16, addr=0xBEEF: expect start=1, read=1, address=0xBEEF in one cycle.
- Drive resetN=0 during the second read beat of a len=3 burst. Expect the bus released in that cycle, no done, state IDLE, and the next request proceeding normally.
